alu_operand_collector: RTL and testbench
========================================

Name: alu_operand_collector

Overview:
Front-end receiver for the ALU stimulus protocol. It accepts OPA/OPB/Cin/mode/CMD qualified by inp_valid, where the two operands may arrive in separate cycles, and enforces the 16-cycle second-operand timeout. It then presents one complete, registered operation to the ALU execute stage over a valid/ready handshake. It sits between the driver-facing pins and the ALU datapath.

Parameters:
W, 8, operand width
N, 4, command width
TIMEOUT, 16, CE-qualified cycles allowed for the missing operand after the first partial sample

Ports:
clk  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-low (0 = reset)
CE  input  1  clock enable; 0 freezes all state, including the handshake
OPA  input  W  operand A
OPB  input  W  operand B
Cin  input  1  carry in
mode  input  1  1 = arithmetic, 0 = logical
CMD  input  N  command
inp_valid  input  2  bit0 = OPA valid, bit1 = OPB valid
op_ready  input  1  downstream accepts the operation
op_valid  output  1  complete operation available
op_a  output  W  collected operand A
op_b  output  W  collected operand B
op_cin  output  1  collected Cin
op_mode  output  1  collected mode
op_cmd  output  N  collected CMD
op_err  output  1  operation is a timeout error; downstream must raise ERR
busy  output  1  state != IDLE

Behaviour:
- Reset (RST=0, async): state=IDLE, counter=0, all outputs 0. Reset mid-WAIT or mid-ISSUE discards the pending operation with no op_valid.
- CE=0: no input sampling, counter holds, state holds, op_ready ignored, outputs hold.
- All actions below happen at a rising clk edge with CE=1.
- Operand need decode, on the mode/CMD captured at first sample:
  - A-only: mode=1 with CMD 4,5; mode=0 with CMD 6,8,9.
  - B-only: mode=1 with CMD 6,7; mode=0 with CMD 7,10,11.
  - Every other mode/CMD needs both operands.
- States: IDLE, WAIT_A, WAIT_B, ISSUE.
- IDLE:
  - inp_valid=00: stay in IDLE.
  - Any nonzero inp_valid: capture mode, CMD, Cin and every operand whose valid bit is set.
  - All needed operands present: go to ISSUE. op_valid=1 the next cycle (latency 1).
  - inp_valid=01 and both needed: go to WAIT_B, counter=0.
  - inp_valid=10 and both needed: go to WAIT_A, counter=0.
- WAIT_A / WAIT_B:
  - CMD, mode and Cin are frozen from the first sample; later changes are ignored.
  - An already-held operand is never overwritten.
  - Missing operand's valid bit set (01/10/11 as applicable): capture it, go to ISSUE with op_err=0.
  - Otherwise counter increments. When the counter reaches TIMEOUT (16th cycle after the first sample), go to ISSUE with op_err=1. The missing operand field reads 0.
- ISSUE:
  - op_valid=1 and all op_* fields stable until the handshake completes.
  - Handshake completes on op_valid&&op_ready. op_valid drops the next cycle unless a new operation is issued.
  - In the handshake cycle the inputs are sampled exactly as in IDLE, giving back-to-back throughput of 1 op/cycle when both operands arrive together.
  - Without handshake: inputs are ignored and busy=1. Upstream must hold its data.
- op_err=1 only together with op_valid=1. It clears when the next operation is issued.
- Counter width is ceil(log2(TIMEOUT+1)). It never wraps; it saturates at TIMEOUT.

Test Plan:
- Reset: RST=0 mid-WAIT_B with counter=7 -> op_valid=0, busy=0, all outputs 0 immediately, asynchronously; after release, IDLE.
- Full op: mode=1, CMD=0, OPA=8'h12, OPB=8'h34, inp_valid=11, op_ready=1 -> op_valid=1 the next cycle with op_a=12, op_b=34, op_err=0; back-to-back ops accepted every cycle.
- Split op: inp_valid=01 with OPA=8'hAA, then 5 idle cycles, then inp_valid=10 with OPB=8'h55 -> op_valid one cycle later with op_a=AA, op_b=55; CMD is from the first sample even if changed in between.
- Timeout: inp_valid=10 with mode=1, CMD=0, then 16 cycles of inp_valid=00 -> op_valid=1 with op_err=1 one cycle after the 16th; then inp_valid=01 at cycle 15 in a second run -> op_err=0.
- Single-operand: mode=1, CMD=4, inp_valid=01 -> immediate issue, no WAIT. Mode=0, CMD=10, inp_valid=10 -> immediate issue.
- Backpressure/CE: op_ready=0 for 4 cycles with changing inputs -> op_* stable, inputs ignored. CE=0 during WAIT for 10 cycles -> counter frozen, timeout still at 16 CE cycles.

Source files
------------

// File: rtl/alu_operand_collector.sv
// alu_operand_collector: gathers OPA/OPB/Cin/mode/CMD from the driver-facing
// pins, possibly across several cycles, and hands one registered operation to
// the ALU execute stage over a valid/ready handshake. If the second operand
// does not arrive within TIMEOUT enabled cycles, the operation is issued with
// op_err set and the missing operand reads as zero.
module alu_operand_collector #(
  parameter int unsigned W       = 8,
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         CE,
  input  logic [W-1:0] OPA,
  input  logic [W-1:0] OPB,
  input  logic         Cin,
  input  logic         mode,
  input  logic [N-1:0] CMD,
  input  logic [1:0]   inp_valid,
  input  logic         op_ready,
  output logic         op_valid,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic         op_cin,
  output logic         op_mode,
  output logic [N-1:0] op_cmd,
  output logic         op_err,
  output logic         busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT_A = 2'd1;
  localparam logic [1:0] S_WAIT_B = 2'd2;
  localparam logic [1:0] S_ISSUE  = 2'd3;

  // Counter value at which the next empty wait cycle is the final allowed one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  // Commands that consume only operand A.
  function automatic logic a_only(input logic m, input logic [N-1:0] c);
    if (m) a_only = (c == N'(4)) || (c == N'(5));
    else   a_only = (c == N'(6)) || (c == N'(8)) || (c == N'(9));
  endfunction

  // Commands that consume only operand B.
  function automatic logic b_only(input logic m, input logic [N-1:0] c);
    if (m) b_only = (c == N'(6)) || (c == N'(7));
    else   b_only = (c == N'(7)) || (c == N'(10)) || (c == N'(11));
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic         valid_d;
  logic         err_d;
  logic [W-1:0] a_d;
  logic [W-1:0] b_d;
  logic         cin_d;
  logic         mode_d;
  logic [N-1:0] cmd_d;
  logic         busy_d;

  logic         take;
  logic         need_a;
  logic         need_b;

  // Operand need of the operation being sampled right now.
  always_comb begin
    need_a = ~b_only(mode, CMD);
    need_b = ~a_only(mode, CMD);
  end

  // State and counter register; CE=0 freezes everything.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (CE) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and operation register contents.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = op_valid;
    err_d   = op_err;
    a_d     = op_a;
    b_d     = op_b;
    cin_d   = op_cin;
    mode_d  = op_mode;
    cmd_d   = op_cmd;
    take    = 1'b0;

    case (state_q)
      S_IDLE: begin
        take = 1'b1;
      end

      S_WAIT_A: begin
        if (inp_valid[0]) begin
          a_d     = OPA;
          valid_d = 1'b1;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_MAX;
          valid_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_ISSUE;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_B: begin
        if (inp_valid[1]) begin
          b_d     = OPB;
          valid_d = 1'b1;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_MAX;
          valid_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_ISSUE;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ISSUE: begin
        // Inputs are only looked at in the handshake cycle.
        take = op_ready;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Sample a fresh operation (idle, or the cycle the previous one is taken).
    if (take) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
      state_d = S_IDLE;
      if (inp_valid != 2'b00) begin
        mode_d = mode;
        cmd_d  = CMD;
        cin_d  = Cin;
        a_d    = inp_valid[0] ? OPA : '0;
        b_d    = inp_valid[1] ? OPB : '0;
        if (need_a && !inp_valid[0]) begin
          state_d = S_WAIT_A;
          cnt_d   = '0;
        end else if (need_b && !inp_valid[1]) begin
          state_d = S_WAIT_B;
          cnt_d   = '0;
        end else begin
          state_d = S_ISSUE;
          valid_d = 1'b1;
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // Registered operation presented to the execute stage.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      op_valid <= 1'b0;
      op_err   <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      op_mode  <= 1'b0;
      op_cmd   <= '0;
      busy     <= 1'b0;
    end else if (CE) begin
      op_valid <= valid_d;
      op_err   <= err_d;
      op_a     <= a_d;
      op_b     <= b_d;
      op_cin   <= cin_d;
      op_mode  <= mode_d;
      op_cmd   <= cmd_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_collector.sv
// Bench for alu_operand_collector: directed scenarios plus random traffic,
// all checked against a transaction-level model of the collector.
module tb_alu_operand_collector;

  localparam int unsigned W       = 8;
  localparam int unsigned N       = 4;
  localparam int unsigned TIMEOUT = 16;

  logic         clk;
  logic         RST;
  logic         CE;
  logic [W-1:0] OPA;
  logic [W-1:0] OPB;
  logic         Cin;
  logic         mode;
  logic [N-1:0] CMD;
  logic [1:0]   inp_valid;
  logic         op_ready;
  logic         op_valid;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         op_mode;
  logic [N-1:0] op_cmd;
  logic         op_err;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_operand_collector #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .RST(RST), .CE(CE),
    .OPA(OPA), .OPB(OPB), .Cin(Cin), .mode(mode), .CMD(CMD),
    .inp_valid(inp_valid), .op_ready(op_ready),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .op_mode(op_mode), .op_cmd(op_cmd), .op_err(op_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one issued slot plus one half-collected operation.
  bit       m_valid, m_err, m_cin, m_mode;
  bit [7:0] m_a, m_b;
  bit [3:0] m_cmd;
  bit       m_pend;
  bit       m_miss_a;
  int       m_age;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit uses_only_a(bit md, int c);
    return md ? (c == 4 || c == 5) : (c == 6 || c == 8 || c == 9);
  endfunction

  function automatic bit uses_only_b(bit md, int c);
    return md ? (c == 6 || c == 7) : (c == 7 || c == 10 || c == 11);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_err = 0; m_cin = 0; m_mode = 0;
    m_a = 0; m_b = 0; m_cmd = 0; m_pend = 0; m_miss_a = 0; m_age = 0;
  endtask

  // One enabled clock edge of the collector, from the current pin values.
  task automatic model_step();
    bit accept = 0;
    bit arrived;
    if (m_valid) begin
      if (op_ready) begin
        m_valid = 0;
        m_err   = 0;
        accept  = 1;
      end
    end else if (m_pend) begin
      arrived = m_miss_a ? inp_valid[0] : inp_valid[1];
      if (arrived) begin
        if (m_miss_a) m_a = OPA; else m_b = OPB;
        m_pend = 0; m_valid = 1; m_err = 0;
      end else begin
        m_age++;
        if (m_age == TIMEOUT) begin
          m_pend = 0; m_valid = 1; m_err = 1;
        end
      end
    end else begin
      accept = 1;
    end

    if (accept && inp_valid != 2'b00) begin
      bit na = !uses_only_b(mode, int'(CMD));
      bit nb = !uses_only_a(mode, int'(CMD));
      m_mode = mode; m_cmd = CMD; m_cin = Cin;
      m_a = inp_valid[0] ? OPA : 8'h00;
      m_b = inp_valid[1] ? OPB : 8'h00;
      if ((na && !inp_valid[0]) || (nb && !inp_valid[1])) begin
        m_pend   = 1;
        m_miss_a = na && !inp_valid[0];
        m_age    = 0;
      end else begin
        m_valid = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("op_valid", 32'(op_valid), 32'(m_valid));
    chk("op_err", 32'(op_err), 32'(m_err));
    chk("busy", 32'(busy), 32'(m_valid || m_pend));
    if (m_valid) begin
      chk("op_a", 32'(op_a), 32'(m_a));
      chk("op_b", 32'(op_b), 32'(m_b));
      chk("op_cin", 32'(op_cin), 32'(m_cin));
      chk("op_mode", 32'(op_mode), 32'(m_mode));
      chk("op_cmd", 32'(op_cmd), 32'(m_cmd));
    end
  endtask

  // Drive one cycle at the falling edge, then check just after the rising edge.
  task automatic drive(input bit ce, input logic [1:0] iv, input logic [7:0] a,
                       input logic [7:0] b, input logic cin, input logic md,
                       input logic [3:0] cmd, input logic rdy);
    @(negedge clk);
    CE = ce; inp_valid = iv; OPA = a; OPB = b; Cin = cin; mode = md; CMD = cmd;
    op_ready = rdy;
    if (ce) model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1, 2'b00, 8'hEE, 8'hEE, 1, 0, 4'd13, rdy);
  endtask

  initial begin
    RST = 0; CE = 0; OPA = 0; OPB = 0; Cin = 0; mode = 0; CMD = 0;
    inp_valid = 0; op_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(op_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    RST = 1;

    // Full operation, then back-to-back issue.
    drive(1, 2'b11, 8'h12, 8'h34, 0, 1, 4'd0, 1);
    chk("full_valid", 32'(op_valid), 32'd1);
    chk("full_a", 32'(op_a), 32'h12);
    chk("full_b", 32'(op_b), 32'h34);
    chk("full_err", 32'(op_err), 32'd0);
    drive(1, 2'b11, 8'h56, 8'h78, 1, 1, 4'd1, 1);
    chk("b2b_valid", 32'(op_valid), 32'd1);
    chk("b2b_a", 32'(op_a), 32'h56);
    idle(1, 1);
    chk("b2b_drop", 32'(op_valid), 32'd0);

    // Split operation; CMD changes in between are ignored.
    drive(1, 2'b01, 8'hAA, 8'h00, 1, 1, 4'd0, 1);
    for (int i = 0; i < 5; i++) drive(1, 2'b00, 8'h11, 8'h22, 0, 0, 4'd3, 1);
    drive(1, 2'b10, 8'h01, 8'h55, 0, 0, 4'd9, 1);
    chk("split_a", 32'(op_a), 32'hAA);
    chk("split_b", 32'(op_b), 32'h55);
    chk("split_cmd", 32'(op_cmd), 32'd0);
    idle(1, 1);

    // Timeout with A missing.
    drive(1, 2'b10, 8'h00, 8'h77, 0, 1, 4'd0, 1);
    idle(15, 1);
    chk("to_early", 32'(op_valid), 32'd0);
    idle(1, 1);
    chk("to_valid", 32'(op_valid), 32'd1);
    chk("to_err", 32'(op_err), 32'd1);
    chk("to_a_zero", 32'(op_a), 32'd0);
    chk("to_b", 32'(op_b), 32'h77);
    idle(1, 1);
    chk("to_err_clr", 32'(op_err), 32'd0);

    // Missing operand arrives on the 15th cycle: no error.
    drive(1, 2'b10, 8'h00, 8'h44, 0, 1, 4'd0, 1);
    idle(14, 1);
    drive(1, 2'b01, 8'h33, 8'h00, 0, 1, 4'd2, 1);
    chk("late_valid", 32'(op_valid), 32'd1);
    chk("late_err", 32'(op_err), 32'd0);
    chk("late_a", 32'(op_a), 32'h33);
    idle(1, 1);

    // Single-operand commands issue immediately.
    drive(1, 2'b01, 8'h9C, 8'h00, 0, 1, 4'd4, 1);
    chk("aonly_valid", 32'(op_valid), 32'd1);
    drive(1, 2'b10, 8'h00, 8'h6D, 0, 0, 4'd10, 1);
    chk("bonly_valid", 32'(op_valid), 32'd1);
    chk("bonly_cmd", 32'(op_cmd), 32'd10);
    idle(1, 1);

    // Backpressure: outputs hold, inputs ignored.
    drive(1, 2'b11, 8'hC3, 8'h3C, 1, 1, 4'd2, 0);
    for (int i = 0; i < 4; i++)
      drive(1, 2'b11, 8'($urandom), 8'($urandom), 0, 0, 4'($urandom), 0);
    chk("bp_a", 32'(op_a), 32'hC3);
    chk("bp_b", 32'(op_b), 32'h3C);
    chk("bp_busy", 32'(busy), 32'd1);
    idle(1, 1);

    // CE low during a wait does not consume timeout budget.
    drive(1, 2'b10, 8'h00, 8'h99, 0, 1, 4'd0, 1);
    idle(5, 1);
    for (int i = 0; i < 10; i++) drive(0, 2'b11, 8'h01, 8'h02, 0, 0, 4'd5, 1);
    idle(10, 1);
    chk("ce_early", 32'(op_valid), 32'd0);
    idle(1, 1);
    chk("ce_valid", 32'(op_valid), 32'd1);
    chk("ce_err", 32'(op_err), 32'd1);
    idle(1, 1);

    // Asynchronous reset while waiting for B with counter at 7.
    drive(1, 2'b01, 8'hAA, 8'h00, 1, 1, 4'd0, 1);
    idle(7, 1);
    @(negedge clk);
    #2;
    RST = 0;
    #1;
    model_reset();
    chk("arst_valid", 32'(op_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_a", 32'(op_a), 32'd0);
    chk("arst_mode", 32'(op_mode), 32'd0);
    chk("arst_cin", 32'(op_cin), 32'd0);
    @(negedge clk);
    RST = 1;
    idle(3, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] iv;
      int r = int'($urandom_range(0, 9));
      iv = (r < 3) ? 2'b00 : (r < 6) ? 2'b11 : (r < 8) ? 2'b01 : 2'b10;
      drive(($urandom_range(0, 9) != 0), iv, 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
